serial_adder: RTL and testbench

- Bit-serial N-bit ripple adder: a = d + b + bin, the inverse of the team's subtractor datapath. Downstream logic uses it to reconstruct the minuend from the difference and subtrahend, and to check the subtractor in-system.
- Operands are captured on a start pulse.
- One full-adder bit is resolved per clock, LSB first, through a registered carry flip-flop.
- The result is presented with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder computing {cout,sum} = a + b + cin.
// One full-adder bit is resolved per clock, LSB first, through a registered
// carry flop. Operands are captured on start and the result is announced
// with a one-cycle done pulse. sum/cout hold the last result between runs.
module serial_adder #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    assign busy = (state == RUN);

    // Full-adder slice on the current LSBs plus the result register with the new bit entering at the MSB
    always_comb begin
        s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        res_next = res_sh >> 1;
        res_next[WIDTH-1] = s_bit;
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, operand shifting, carry flop and result/done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= c_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= IDLE;
                        sum   <= res_next;
                        cout  <= c_next;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder. Stimulus pushes each
// accepted operation into a queue; a negedge monitor pops on done and checks
// the result against plain integer addition, the latency, and the inverse
// subtraction. It also checks busy length and output hold while busy.
module tb_serial_adder;

    localparam int W = 2;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int unsigned  acc;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          done_count = 0;
    op_t         q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done against the accepting edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on done, busy-length and output-hold checks
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    logic aborted = 1'b0;
    int   held = 0;
    always @(negedge clk) begin
        op_t e;
        int  exp_val;
        int  act_val;
        int  d;
        if (done === 1'b1) begin
            done_count++;
            chk("done_busy_low", int'(busy), 0);
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                exp_val = int'(e.a) + int'(e.b) + int'(e.cin);
                act_val = int'({cout, sum});
                chk("result", act_val, exp_val);
                chk("latency", int'(cyc), int'(e.acc) + W);
                d = (int'(sum) - int'(e.b) - int'(e.cin)) & MASK;
                chk("inverse_sub", d, int'(e.a));
                held = exp_val;
            end
        end
        if (busy === 1'b1) begin
            busy_len++;
            chk("hold_while_busy", int'({cout, sum}), held);
            chk("no_done_while_busy", int'(done), 0);
        end else if (prev_busy) begin
            if (!aborted) chk("busy_len", busy_len, W);
            busy_len = 0;
            aborted = 1'b0;
        end
        if (rst === 1'b1) begin
            aborted = 1'b1;
            held = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        op_t e;
        wait_idle();
        start = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        e.a = ia;
        e.b = ib;
        e.cin = ic;
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_cout", int'(cout), 0);
    endtask

    initial begin
        int dc;
        int n;
        @(posedge clk); #1;
        do_reset();

        // Directed operations, issued back-to-back
        issue(W'(3), W'(1), 1'b0);
        issue(W'(2), W'(1), 1'b1);
        issue(W'(0), W'(0), 1'b0);

        // Exhaustive sweep
        for (int ia = 0; ia <= MASK; ia++)
            for (int ib = 0; ib <= MASK; ib++)
                for (int ic = 0; ic < 2; ic++)
                    issue(W'(ia), W'(ib), 1'(ic));
        wait_idle();
        repeat (2) @(posedge clk); #1;

        // start while busy must be ignored
        dc = done_count;
        issue(W'(1), W'(1), 1'b0);
        start = 1'b1;
        a = W'(3);
        b = W'(3);
        cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk); #1;
        chk("ignored_start_done_count", done_count - dc, 1);

        // Reset after one RUN edge aborts the operation
        issue(W'(3), W'(3), 1'b1);
        @(posedge clk); #1;
        do_reset();
        chk("abort_no_done", q.size(), 1);
        q.delete();
        repeat (2) @(posedge clk); #1;
        chk("abort_quiet_done", int'(done), 0);
        issue(W'(3), W'(3), 1'b1);

        // Randomized operations with random idle gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            issue(W'($urandom), W'($urandom), 1'($urandom));
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        repeat (3) @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
